// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Drives the pipeline latch enables and clears, the PC enable, halt drain and a stall counter.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_dmemREN,
    input  logic [4:0]       idex_wsel,
    input  logic             idex_hlt,
    input  logic             exmem_dmemREN,
    input  logic             exmem_dmemWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_sRST,
    output logic             idex_en,
    output logic             idex_sRST,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [DW-1:0]    drain_q;
    logic [DW-1:0]    drain_d;
    logic [CNT_W-1:0] stall_q;

    logic mem_stall;
    logic rs_hit;
    logic rt_hit;
    logic load_use;
    logic stall_inc;

    // Hazard terms; r0 is never a real producer so it cannot cause a load-use stall.
    always_comb begin
        mem_stall = (exmem_dmemREN | exmem_dmemWEN) & ~dhit;
        rs_hit    = (idex_wsel == ifid_rs);
        rt_hit    = ifid_uses_rt & (idex_wsel == ifid_rt);
        load_use  = idex_dmemREN & (idex_wsel != 5'd0) & (rs_hit | rt_hit);
    end

    // Next state and latch controls; earlier RUN conditions take priority.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        ifid_sRST = 1'b0;
        idex_en   = 1'b0;
        idex_sRST = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
        if (nRST) begin
            unique case (state_q)
                RUN: begin
                    priority case (1'b1)
                        mem_stall: begin
                        end
                        idex_hlt: begin
                            ifid_en   = 1'b1;
                            ifid_sRST = 1'b1;
                            idex_en   = 1'b1;
                            idex_sRST = 1'b1;
                            exmem_en  = 1'b1;
                            memwb_en  = 1'b1;
                            state_d   = DRAIN;
                            drain_d   = DRAIN_LOAD;
                        end
                        ex_branch_taken: begin
                            pc_en     = 1'b1;
                            ifid_en   = 1'b1;
                            ifid_sRST = 1'b1;
                            idex_en   = 1'b1;
                            idex_sRST = 1'b1;
                            exmem_en  = 1'b1;
                            memwb_en  = 1'b1;
                        end
                        load_use: begin
                            idex_en   = 1'b1;
                            idex_sRST = 1'b1;
                            exmem_en  = 1'b1;
                            memwb_en  = 1'b1;
                        end
                        ~ihit: begin
                            ifid_en   = 1'b1;
                            ifid_sRST = 1'b1;
                            idex_en   = 1'b1;
                            exmem_en  = 1'b1;
                            memwb_en  = 1'b1;
                        end
                        default: begin
                            pc_en    = 1'b1;
                            ifid_en  = 1'b1;
                            idex_en  = 1'b1;
                            exmem_en = 1'b1;
                            memwb_en = 1'b1;
                        end
                    endcase
                end
                DRAIN: begin
                    ifid_en   = 1'b1;
                    ifid_sRST = 1'b1;
                    idex_en   = 1'b1;
                    idex_sRST = 1'b1;
                    if (!mem_stall) begin
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        if (drain_q == '0) begin
                            state_d = HALTED;
                        end else begin
                            drain_d = drain_q - 1'b1;
                        end
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // A stalled fetch outside HALTED bumps the counter.
    always_comb begin
        stall_inc = (state_q != HALTED) & ~pc_en & nRST;
    end

    // FSM and drain counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Status outputs.
    always_comb begin
        halt      = (state_q == HALTED);
        stall_cnt = stall_q;
    end

endmodule
